// File: rtl/turbo_pkg.sv
// turbo_pkg: shared types and defaults for the turbo decoder iteration controller.
//   state_t     - controller FSM states
//   DEF_*       - default block size, iteration limit and SISO watchdog timeout
//   ITER_W      - iteration counter width
//   HDC_W       - hard-decision change count width
//   clamp_iter  - maps a requested iteration count into 1..max_iter
package turbo_pkg;
   localparam int DEF_N        = 256;
   localparam int DEF_MAX_ITER = 6;
   localparam int DEF_TIMEOUT  = 4096;
   localparam int ITER_W       = 4;
   localparam int HDC_W        = $clog2(DEF_N) + 1;

   typedef enum logic [2:0] {IDLE, RUN1, WAIT1, RUN2, WAIT2, DONE} state_t;

   function automatic logic [ITER_W-1:0] clamp_iter(input logic [ITER_W-1:0] req, input int max_iter);
      return (req == '0) ? ITER_W'(1) : (int'(req) > max_iter) ? ITER_W'(max_iter) : req;
   endfunction
endpackage

// File: rtl/turbo_wdog.sv
// turbo_wdog: SISO watchdog counter.
//   clk, reset - clock, asynchronous active-high reset
//   clr        - restart the count (asserted while siso_start is visible)
//   en         - count while the controller waits for siso_done
//   expire     - combinational pulse in the last cycle a siso_done is still accepted
module turbo_wdog
   import turbo_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expire
);
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt;

   // The clear cycle is the start cycle itself, so loading 1 makes cnt equal the
   // number of cycles elapsed since the start; the registered err that follows
   // expire then lands exactly TIMEOUT cycles after siso_start.
   always_ff @(posedge clk or posedge reset)
      if (reset)
         cnt <= '0;
      else if (clr)
         cnt <= CW'(1);
      else if (en)
         cnt <= cnt + 1'b1;

   assign expire = en && !clr && (cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/turbo_iter_ctrl.sv
// turbo_iter_ctrl: iteration scheduler for a shared-SISO turbo decoder.
//   clk, reset            - clock, asynchronous active-high reset
//   blk_valid/blk_ready   - input block handshake; iter_limit sampled on it
//   siso_start            - one-cycle SISO kick-off, with siso_dec_sel/siso_il_en
//   siso_done/hd_changes  - SISO completion and hard-decision flip count
//   llr_bank              - extrinsic bank read by the SISO (it writes the other)
//   iter_count            - completed full iterations of the current block
//   out_valid/out_ready   - decoded block handoff to the output stage
//   early_stop            - block finished before its iteration limit
//   err                   - one-cycle watchdog expiry pulse
// Optional feature: define TURBO_EARLY_STOP_EN to stop once a whole iteration
// produces no hard-decision changes; otherwise hd_changes is ignored.
module turbo_iter_ctrl
   import turbo_pkg::*;
#(
   parameter int N        = DEF_N,
   parameter int MAX_ITER = DEF_MAX_ITER,
   parameter int TIMEOUT  = DEF_TIMEOUT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              blk_valid,
   output logic              blk_ready,
   input  logic [ITER_W-1:0] iter_limit,
   output logic              siso_start,
   output logic              siso_dec_sel,
   output logic              siso_il_en,
   input  logic              siso_done,
   input  logic [$clog2(N):0] hd_changes,
   output logic              llr_bank,
   output logic [ITER_W-1:0] iter_count,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              early_stop,
   output logic              err
);
   state_t            state;
   logic [ITER_W-1:0] lim;
   logic [ITER_W-1:0] iter_nxt;
   logic              wd_exp;
   logic              es_hit;

   assign iter_nxt = iter_count + 1'b1;

   turbo_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
      .clk    (clk),
      .reset  (reset),
      .clr    (siso_start),
      .en     (state == WAIT1 || state == WAIT2),
      .expire (wd_exp)
   );

`ifdef TURBO_EARLY_STOP_EN
   logic hd1_zero;

   always_ff @(posedge clk or posedge reset)
      if (reset)
         hd1_zero <= 1'b0;
      else if (state == WAIT1 && siso_done)
         hd1_zero <= (hd_changes == '0);

   assign es_hit = hd1_zero && (hd_changes == '0);
`else
   logic unused_hdc;

   assign unused_hdc = ^hd_changes;
   assign es_hit     = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state        <= IDLE;
         lim          <= '0;
         blk_ready    <= 1'b0;
         siso_start   <= 1'b0;
         siso_dec_sel <= 1'b0;
         siso_il_en   <= 1'b0;
         llr_bank     <= 1'b0;
         iter_count   <= '0;
         out_valid    <= 1'b0;
         early_stop   <= 1'b0;
         err          <= 1'b0;
      end else begin
         siso_start <= 1'b0;
         err        <= 1'b0;
         case (state)
            IDLE: begin
               blk_ready <= 1'b1;
               if (blk_valid && blk_ready) begin
                  blk_ready  <= 1'b0;
                  lim        <= clamp_iter(iter_limit, MAX_ITER);
                  iter_count <= '0;
                  llr_bank   <= 1'b0;
                  early_stop <= 1'b0;
                  state      <= RUN1;
               end
            end
            RUN1: begin
               siso_start   <= 1'b1;
               siso_dec_sel <= 1'b0;
               siso_il_en   <= 1'b0;
               state        <= WAIT1;
            end
            WAIT1:
               // siso_done takes priority over a same-cycle watchdog expiry
               if (siso_done) begin
                  llr_bank <= ~llr_bank;
                  state    <= RUN2;
               end else if (wd_exp) begin
                  err        <= 1'b1;
                  iter_count <= '0;
                  blk_ready  <= 1'b1;
                  state      <= IDLE;
               end
            RUN2: begin
               siso_start   <= 1'b1;
               siso_dec_sel <= 1'b1;
               siso_il_en   <= 1'b1;
               state        <= WAIT2;
            end
            WAIT2:
               if (siso_done) begin
                  llr_bank   <= ~llr_bank;
                  iter_count <= iter_nxt;
                  if (iter_nxt == lim) begin
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end else if (es_hit) begin
                     out_valid  <= 1'b1;
                     early_stop <= 1'b1;
                     state      <= DONE;
                  end else
                     state <= RUN1;
               end else if (wd_exp) begin
                  err        <= 1'b1;
                  iter_count <= '0;
                  blk_ready  <= 1'b1;
                  state      <= IDLE;
               end
            DONE:
               if (out_ready) begin
                  out_valid <= 1'b0;
                  blk_ready <= 1'b1;
                  state     <= IDLE;
               end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_turbo_iter_ctrl.sv
// tb_turbo_iter_ctrl: directed scoreboard bench for turbo_iter_ctrl with a behavioural SISO responder.
module tb_turbo_iter_ctrl;
   import turbo_pkg::*;

   localparam int TO = DEF_TIMEOUT;

   typedef struct {
      int   iters;
      logic es;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              blk_valid = 1'b0;
   logic              blk_ready;
   logic [ITER_W-1:0] iter_limit = '0;
   logic              siso_start;
   logic              siso_dec_sel;
   logic              siso_il_en;
   logic              siso_done = 1'b0;
   logic [HDC_W-1:0]  hd_changes = '0;
   logic              llr_bank;
   logic [ITER_W-1:0] iter_count;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic              early_stop;
   logic              err;

   exp_t             exp_q[$];
   int               checks = 0;
   int               failures = 0;
   int               cyc = 0;
   int               nstart = 0;
   int               n_err = 0;
   int               last_done_cyc = 0;
   int               resp_dly = 10;
   logic [HDC_W-1:0] hd_tab [0:31];

   turbo_iter_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .blk_valid    (blk_valid),
      .blk_ready    (blk_ready),
      .iter_limit   (iter_limit),
      .siso_start   (siso_start),
      .siso_dec_sel (siso_dec_sel),
      .siso_il_en   (siso_il_en),
      .siso_done    (siso_done),
      .hd_changes   (hd_changes),
      .llr_bank     (llr_bank),
      .iter_count   (iter_count),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .early_stop   (early_stop),
      .err          (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (err) n_err++;
   end

   // SISO model: k-th start of a block must use decoder k%2 and read bank k%2;
   // it answers resp_dly cycles later (never when resp_dly is 0).
   initial begin
      int k;
      int d;
      forever begin
         @(posedge clk);
         #1;
         if (siso_start) begin
            k = nstart;
            nstart++;
            chk("start_sel", {30'd0, siso_dec_sel, siso_il_en}, k[0] ? 32'd3 : 32'd0);
            chk("start_bank", {31'd0, llr_bank}, {31'd0, k[0]});
            d = resp_dly;
            if (d > 0) begin
               repeat (d) @(posedge clk);
               #1;
               siso_done     = 1'b1;
               hd_changes    = hd_tab[k % 32];
               last_done_cyc = cyc;
               @(posedge clk);
               #1;
               siso_done  = 1'b0;
               hd_changes = '0;
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1);
   end

   task automatic wait_ready();
      for (int t = 0; t < 50 && !blk_ready; t++) begin
         @(posedge clk);
         #1;
      end
      chk("ready_wait", {31'd0, blk_ready}, 32'd1);
   endtask

   task automatic handshake(input logic [ITER_W-1:0] l);
      wait_ready();
      nstart     = 0;
      blk_valid  = 1'b1;
      iter_limit = l;
      @(posedge clk);
      #1;
      blk_valid = 1'b0;
      chk("ready_low", {31'd0, blk_ready}, 32'd0);
      chk("start_lat0", {31'd0, siso_start}, 32'd0);
      @(posedge clk);
      #1;
      chk("start_lat1", {31'd0, siso_start}, 32'd1);
   endtask

   task automatic run_block(input logic [ITER_W-1:0] l, input int it, input logic es, input int hold);
      exp_t e;
      logic bad;
      handshake(l);
      exp_q.push_back('{it, es});
      for (int t = 0; t < 20000 && !out_valid; t++) begin
         @(posedge clk);
         #1;
      end
      chk("ov_seen", {31'd0, out_valid}, 32'd1);
      if (!out_valid) return;
      chk("ov_lat", cyc - last_done_cyc, 32'd1);
      e = exp_q.pop_front();
      chk("iter_count", {28'd0, iter_count}, e.iters);
      chk("early_stop", {31'd0, early_stop}, {31'd0, e.es});
      chk("bank_end", {31'd0, llr_bank}, 32'd0);
      chk("n_starts", nstart, 2 * e.iters);
      bad = 1'b0;
      repeat (hold) begin
         @(posedge clk);
         #1;
         if (!out_valid || blk_ready) bad = 1'b1;
      end
      if (hold > 0) chk("hold_done", {31'd0, bad}, 32'd0);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("ov_drop", {31'd0, out_valid}, 32'd0);
      chk("ready_back", {31'd0, blk_ready}, 32'd1);
   endtask

   initial begin
      int   st;
      int   base;
      logic ov;
      for (int i = 0; i < 32; i++) hd_tab[i] = HDC_W'(5);
      repeat (3) @(posedge clk);
      #1;
      chk("reset_vals", {20'd0, blk_ready, siso_start, siso_dec_sel, siso_il_en, llr_bank,
                         iter_count, out_valid, early_stop, err}, 32'd0);
      reset = 1'b0;
      chk("ready_post_reset", {31'd0, blk_ready}, 32'd0);
      @(posedge clk);
      #1;
      chk("ready_idle", {31'd0, blk_ready}, 32'd1);

      run_block(4'd3, 3, 1'b0, 0);
      run_block(4'd0, 1, 1'b0, 0);
      run_block(4'd9, 6, 1'b0, 20);

      hd_tab[2] = '0;
      hd_tab[3] = '0;
`ifdef TURBO_EARLY_STOP_EN
      run_block(4'd6, 2, 1'b1, 0);
`else
      run_block(4'd6, 6, 1'b0, 0);
`endif
      run_block(4'd2, 2, 1'b0, 0);
      hd_tab[2] = HDC_W'(5);
      hd_tab[3] = HDC_W'(5);

      resp_dly = 0;
      handshake(4'd3);
      st = cyc;
      ov = 1'b0;
      for (int t = 0; t < TO + 20 && !err; t++) begin
         @(posedge clk);
         #1;
         ov = ov | out_valid;
      end
      chk("err_lat", cyc - st, TO);
      chk("err_iter", {28'd0, iter_count}, 32'd0);
      chk("err_ready", {31'd0, blk_ready}, 32'd1);
      @(posedge clk);
      #1;
      chk("err_pulse", {31'd0, err}, 32'd0);
      repeat (5) begin
         @(posedge clk);
         #1;
         ov = ov | out_valid;
      end
      chk("err_no_ov", {31'd0, ov}, 32'd0);

      resp_dly = TO - 1;
      base = n_err;
      run_block(4'd1, 1, 1'b0, 0);
      chk("edge_no_err", n_err, base);

      resp_dly = 10;
      handshake(4'd6);
      for (int t = 0; t < 500 && nstart < 4; t++) begin
         @(posedge clk);
         #1;
      end
      chk("rst_reach_wait2", nstart, 32'd4);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("rst_async", {20'd0, blk_ready, siso_start, siso_dec_sel, siso_il_en, llr_bank,
                        iter_count, out_valid, early_stop, err}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      chk("rst_stray_done", {26'd0, llr_bank, iter_count, out_valid}, 32'd0);
      chk("rst_no_start", nstart, 32'd4);

      run_block(4'd2, 2, 1'b0, 0);
      chk("scoreboard_empty", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
